// File: rtl/hvrx_chan.sv
// hvrx_chan: TMDS channel receiver with bitslip word alignment and a two-stage decoder.
// Define HVRX_STATS_EN to add o_slip_cnt, a saturating count of bitslip pulses.
module hvrx_chan #(
  parameter int LOCK_TOKENS  = 16,
  parameter int SEARCH_LIMIT = 4096,
  parameter int SLIP_WAIT    = 4
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic [9:0]  i_symbol,
  output logic        o_bitslip,
  output logic        o_locked,
  output logic        o_de,
  output logic [1:0]  o_ctl,
  output logic [7:0]  o_video
`ifdef HVRX_STATS_EN
  ,output logic [15:0] o_slip_cnt
`endif
);
  localparam int RW = $clog2(LOCK_TOKENS + 1);
  localparam int TW = $clog2(SEARCH_LIMIT + 1);
  localparam int WW = $clog2(SLIP_WAIT + 1);
  localparam logic [RW-1:0] RUN_MAX  = RW'(LOCK_TOKENS);
  localparam logic [TW-1:0] TMO_MAX  = TW'(SEARCH_LIMIT - 1);
  localparam logic [WW-1:0] WAIT_MAX = WW'(SLIP_WAIT - 1);
  localparam logic [9:0] T00 = 10'b1101010100;
  localparam logic [9:0] T01 = 10'b0010101011;
  localparam logic [9:0] T10 = 10'b0101010100;
  localparam logic [9:0] T11 = 10'b1010101011;

  typedef enum logic [1:0] {SEARCH, SLIP, WAIT, LOCKED} state_t;

  state_t state, state_nxt;
  logic [9:0] sym;
  logic [RW-1:0] run, run_nxt;
  logic [TW-1:0] tmo;
  logic [WW-1:0] wcnt;
  logic tok, hit, counting;
  logic [1:0] tok_val;
  logic [7:0] q, d;

  always_comb begin
    tok = sym inside {T00, T01, T10, T11};
    tok_val = {sym == T10 || sym == T11, sym == T01 || sym == T11};
    q = sym[9] ? ~sym[7:0] : sym[7:0];
    d = {sym[8] ? q[7:1] ^ q[6:0] : q[7:1] ~^ q[6:0], q[0]};
    run_nxt = tok ? (run == RUN_MAX ? RUN_MAX : run + 1'b1) : '0;
    hit = run_nxt == RUN_MAX;
    // lock wins over a coincident timeout in both searching and locked states
    state_nxt = state;
    case (state)
      SEARCH:  state_nxt = hit ? LOCKED : (tmo == TMO_MAX ? SLIP : SEARCH);
      SLIP:    state_nxt = WAIT;
      WAIT:    state_nxt = wcnt == WAIT_MAX ? SEARCH : WAIT;
      LOCKED:  state_nxt = !hit && tmo == TMO_MAX ? SEARCH : LOCKED;
      default: state_nxt = SEARCH;
    endcase
    counting = state == SEARCH || state == LOCKED;
  end

  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) begin
      sym       <= '0;
      state     <= SEARCH;
      run       <= '0;
      tmo       <= '0;
      wcnt      <= '0;
      o_bitslip <= 1'b0;
      o_locked  <= 1'b0;
      o_de      <= 1'b0;
      o_ctl     <= '0;
      o_video   <= '0;
    end else begin
      sym       <= i_symbol;
      state     <= state_nxt;
      o_bitslip <= state_nxt == SLIP;
      o_locked  <= state_nxt == LOCKED;
      run       <= counting && state_nxt != SLIP ? run_nxt : '0;
      tmo       <= counting && state_nxt == state && !hit ? tmo + 1'b1 : '0;
      wcnt      <= state == WAIT && state_nxt == WAIT ? wcnt + 1'b1 : '0;
      // decoded outputs are blanked in the same edge that lock is lost or not yet gained
      if (state_nxt != LOCKED) begin
        o_de    <= 1'b0;
        o_ctl   <= '0;
        o_video <= '0;
      end else if (tok) begin
        o_de    <= 1'b0;
        o_ctl   <= tok_val;
      end else begin
        o_de    <= 1'b1;
        o_video <= d;
      end
    end

`ifdef HVRX_STATS_EN
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) o_slip_cnt <= '0;
    else if (state_nxt == SLIP && o_slip_cnt != 16'hFFFF) o_slip_cnt <= o_slip_cnt + 1'b1;
`endif
endmodule

// File: tb/tb_hvrx_chan.sv
// tb_hvrx_chan: directed stimulus for hvrx_chan with a per-cycle reference model,
// a deserializer rotation model and a TMDS encoder for loopback.
module tb_hvrx_chan;
  localparam int LT = 16;
  localparam int SL = 4096;
  localparam int SW = 4;
  localparam logic [9:0] T0 = 10'b1101010100;
  localparam logic [9:0] T1 = 10'b0010101011;
  localparam logic [9:0] T2 = 10'b0101010100;
  localparam logic [9:0] T3 = 10'b1010101011;
  localparam logic [9:0] V0 = 10'b0100000000;
  localparam logic [9:0] V1 = 10'b1000000000;
  localparam logic [9:0] V2 = 10'b0100000001;

  logic clk = 1'b0;
  logic i_rst_n = 1'b0;
  logic [9:0] i_symbol = '0;
  logic o_bitslip, o_locked, o_de;
  logic [1:0] o_ctl;
  logic [7:0] o_video;
`ifdef HVRX_STATS_EN
  logic [15:0] o_slip_cnt;
`endif

  hvrx_chan dut (
    .i_clk(clk), .i_rst_n(i_rst_n), .i_symbol(i_symbol),
    .o_bitslip(o_bitslip), .o_locked(o_locked), .o_de(o_de), .o_ctl(o_ctl), .o_video(o_video)
`ifdef HVRX_STATS_EN
    , .o_slip_cnt(o_slip_cnt)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0, failures = 0;
  int off = 0, cyc = 0, enc_disp = 0;
  int slips[$];

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h at %0t", name, got, exp, $time);
    end
  endtask

  function automatic int tok_code(input logic [9:0] w);
    return w == T0 ? 0 : w == T1 ? 1 : w == T2 ? 2 : w == T3 ? 3 : -1;
  endfunction

  function automatic logic [7:0] ref_dec(input logic [9:0] w);
    logic [7:0] q, d;
    q = w[9] ? ~w[7:0] : w[7:0];
    d[0] = q[0];
    for (int i = 1; i < 8; i++) d[i] = q[i] ^ q[i-1] ^ !w[8];
    return d;
  endfunction

  function automatic logic [9:0] rot(input logic [9:0] w, input int k);
    logic [19:0] ww;
    ww = {w, w} >> k;
    return ww[9:0];
  endfunction

  function automatic logic [9:0] tmds_enc(input logic [7:0] b);
    logic [8:0] qm;
    logic xn;
    int n1, n1q, n0q;
    logic [9:0] o;
    n1 = $countones(b);
    xn = n1 > 4 || (n1 == 4 && !b[0]);
    qm[0] = b[0];
    for (int i = 1; i < 8; i++) qm[i] = xn ? ~(qm[i-1] ^ b[i]) : qm[i-1] ^ b[i];
    qm[8] = !xn;
    n1q = $countones(qm[7:0]);
    n0q = 8 - n1q;
    if (enc_disp == 0 || n1q == n0q) begin
      o = {~qm[8], qm[8], qm[8] ? qm[7:0] : ~qm[7:0]};
      enc_disp += qm[8] ? n1q - n0q : n0q - n1q;
    end else if ((enc_disp > 0 && n1q > n0q) || (enc_disp < 0 && n0q > n1q)) begin
      o = {1'b1, qm[8], ~qm[7:0]};
      enc_disp += 2 * int'(qm[8]) + n0q - n1q;
    end else begin
      o = {1'b0, qm[8], qm[7:0]};
      enc_disp += -2 * int'(!qm[8]) + n1q - n0q;
    end
    return o;
  endfunction

  // Reference model: counts token streaks and idle cycles, with a hold window after each slip
  int m_streak, m_idle, m_hold;
  bit m_locked, m_slip, m_de;
  logic [1:0] m_ctl;
  logic [7:0] m_video;
  logic [9:0] m_prev;

  task automatic model_step(input logic r, input logic [9:0] s);
    int tc;
    if (!r) begin
      m_streak = 0; m_idle = 0; m_hold = 0; m_locked = 0; m_slip = 0;
      m_de = 0; m_ctl = 0; m_video = 0; m_prev = 0;
      return;
    end
    tc = tok_code(m_prev);
    m_slip = 0;
    if (m_hold > 0) begin
      m_hold--; m_streak = 0; m_idle = 0; m_locked = 0;
    end else begin
      m_streak = tc >= 0 ? (m_streak < LT ? m_streak + 1 : LT) : 0;
      if (m_streak == LT) begin
        m_locked = 1; m_idle = 0;
      end else if (m_idle == SL - 1) begin
        m_idle = 0;
        if (m_locked) m_locked = 0;
        else begin m_slip = 1; m_hold = SW + 1; m_streak = 0; end
      end else m_idle++;
    end
    if (!m_locked) begin m_de = 0; m_ctl = 0; m_video = 0; end
    else if (tc >= 0) begin m_de = 0; m_ctl = tc[1:0]; end
    else begin m_de = 1; m_video = ref_dec(m_prev); end
    m_prev = s;
  endtask

  logic [9:0] s_smp;
  logic r_smp;
  always @(posedge clk) begin
    s_smp = i_symbol;
    r_smp = i_rst_n;
    #1;
    model_step(r_smp, s_smp);
    chk("bitslip", 32'(o_bitslip), 32'(m_slip));
    chk("locked", 32'(o_locked), 32'(m_locked));
    chk("de", 32'(o_de), 32'(m_de));
    chk("ctl", 32'(o_ctl), 32'(m_ctl));
    chk("video", 32'(o_video), 32'(m_video));
  end

  task automatic drive(input logic [9:0] w);
    @(negedge clk);
    cyc++;
    if (o_bitslip) begin
      off = off == 0 ? 9 : off - 1;
      slips.push_back(cyc);
    end
    i_symbol = rot(w, off);
  endtask

  task automatic do_reset();
    @(negedge clk);
    i_rst_n = 1'b0;
    i_symbol = '0;
    off = 0;
    repeat (3) @(negedge clk);
    i_rst_n = 1'b1;
  endtask

  bit found;
  initial begin
    repeat (2) @(negedge clk);
    chk("rst_locked", 32'(o_locked), 0);
    chk("rst_outputs", {o_bitslip, o_de, o_ctl, o_video}, 0);
    do_reset();
    repeat (16) drive(T0);
    drive(T0);
    chk("lock_not_yet", 32'(o_locked), 0);
    drive(T0);
    chk("lock_after_16", 32'(o_locked), 1);
    chk("lock_ctl00", {o_de, o_ctl}, 0);
    drive(T1);
    drive(V0);
    drive(V1);
    chk("ctl01", 32'(o_ctl), 1);
    chk("ctl01_de", 32'(o_de), 0);
    drive(V2);
    chk("vid00_de", 32'(o_de), 1);
    chk("vid00", 32'(o_video), 8'h00);
    chk("vid00_ctl", 32'(o_ctl), 1);
    drive(T2);
    chk("vidFF", 32'(o_video), 8'hFF);
    drive(T3);
    chk("vid03", 32'(o_video), 8'h03);
    drive(T0);
    chk("ctl10", 32'(o_ctl), 2);
    chk("ctl10_hold_video", 32'(o_video), 8'h03);
    drive(T0);
    chk("ctl11", 32'(o_ctl), 3);
    repeat (20) drive(T0);
    repeat (4096) drive(V0);
    drive(V0);
    chk("still_locked_4096", 32'(o_locked), 1);
    drive(V0);
    chk("unlock_4096", 32'(o_locked), 0);
    chk("unlock_outputs", {o_bitslip, o_de, o_ctl, o_video}, 0);
    chk("unlock_no_slip", 32'(slips.size()), 0);

    do_reset();
    off = 3;
    slips.delete();
    for (int n = 0; n < 20000 && !o_locked; n++) drive(T0);
    chk("lock_after_slips", 32'(o_locked), 1);
    chk("slip_count", 32'(slips.size()), 3);
    if (slips.size() >= 3) begin
      chk("slip_period1", 32'(slips[1] - slips[0]), 4101);
      chk("slip_period2", 32'(slips[2] - slips[1]), 4101);
    end
`ifdef HVRX_STATS_EN
    chk("stats_cnt3", 32'(o_slip_cnt), 3);
`endif

    do_reset();
    found = 0;
    for (int n = 0; n < 5000 && !found; n++) begin
      drive(V0);
      found = o_bitslip;
    end
    chk("slip_seen", 32'(found), 1);
    i_rst_n = 1'b0;
    #1;
    chk("rst_mid_bitslip", 32'(o_bitslip), 0);
    chk("rst_mid_outputs", {o_locked, o_de, o_ctl, o_video}, 0);
`ifdef HVRX_STATS_EN
    chk("stats_cnt_rst", 32'(o_slip_cnt), 0);
`endif
    repeat (2) @(negedge clk);
    i_rst_n = 1'b1;
    slips.delete();
    repeat (50) drive(V0);
    chk("no_slip_after_rst", 32'(slips.size()), 0);

    do_reset();
    enc_disp = 0;
    repeat (20) drive(T0);
    for (int n = 0; n < 258; n++) begin
      drive(n < 256 ? tmds_enc(8'(n)) : T0);
      if (n >= 2) chk("loopback", 32'(o_video), 32'(n - 2));
    end
    @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
